sram_arbiter: RTL
=================

// Module: sram_arbiter
// PURPOSE
//  Shares the single-port SRAM controller (sram_conn) between two requesters.
//  The first is the framebuffer copy engine (sh_mem VGA copy path, writes only).
//  The second is the VGA scanout (vga_machine, reads only, real-time).
//  Replaces the fixed write/read mux: adds display priority, anti-starvation
//  for the copy port, read-pipeline drain before writes, and write->read bus
//  turnaround.
// PARAMETERS
//  ADDR_W     20  SRAM word address width
//  DATA_W     8   data width, byte lane 0 (byte_en fixed 2'b01 downstream)
//  RD_LAT     2   cycles from mem_read issue to valid mem_rdata (1..7)
//  MAX_DP_RUN 8   max consecutive display grants while cp_req is pending
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  cp_req     in   1       copy write request
//  cp_addr    in   ADDR_W  copy write address
//  cp_wdata   in   DATA_W  copy write data
//  cp_gnt     out  1       copy request accepted this cycle (cp_req & cp_gnt)
//  dp_req     in   1       display read request
//  dp_addr    in   ADDR_W  display read address
//  dp_gnt     out  1       display request accepted this cycle
//  dp_rvalid  out  1       display read data valid
//  dp_rdata   out  DATA_W  display read data
//  mem_write  out  1       to sram_conn.write (registered)
//  mem_read   out  1       to sram_conn.read (registered)
//  mem_addr   out  ADDR_W  to sram_conn.addr (registered)
//  mem_wdata  out  DATA_W  to sram_conn.data_in (registered)
//  mem_rdata  in   DATA_W  from sram_conn.data_out
// BEHAVIOUR
//  Clock, reset and handshake
//  - Single clock domain. Reset is synchronous and active-high.
//  - Reset: all outputs 0, state IDLE, run counter 0, in-flight shift reg 0.
//  - Handshake: a transfer occurs when req & gnt are high in the same cycle.
//  - gnt is combinational from state, counters and req.
//  - Requesters hold addr/data stable while req is high and gnt is low.
//  - An accepted request drives mem_* on the next cycle, for exactly 1 cycle.
//  - mem_write and mem_read are never high together.
//  - With no grant, mem_write = mem_read = 0 and mem_addr/mem_wdata hold.
//  Read tracking
//  - Shift reg infl[RD_LAT:0]: bit 0 is set when mem_read issues.
//  - dp_rvalid = infl[RD_LAT]; dp_rdata = mem_rdata, passed through.
//  - Read latency from grant to dp_rvalid is RD_LAT+1 cycles, in order.
//  FSM (at most one grant per cycle)
//  - IDLE/READ:
//    - If force is set, dp_gnt=0 and go to DRAIN.
//      force = cp_req & (run == MAX_DP_RUN).
//    - Else if dp_req: dp_gnt=1, stay in READ.
//      run increments if cp_req is high, otherwise run clears.
//    - Else if cp_req and infl==0: cp_gnt=1, go to WRITE, run clears.
//    - Else if cp_req: go to DRAIN.
//  - DRAIN: no grants. When infl==0, go to WRITE with cp_gnt=1.
//  - WRITE:
//    - If cp_req: cp_gnt=1, stay in WRITE (back-to-back writes).
//      The exception is dp_req, which takes priority and exits to TURN.
//    - Else go to TURN.
//  - TURN: exactly 1 cycle, no grants, then IDLE. Guarantees >= 1 idle mem
//    cycle between any mem_write and a following mem_read.
//  Boundary conditions
//  - Display priority: with both requests pending in IDLE/READ, dp wins unless
//    force is set.
//  - Copy starvation bound: MAX_DP_RUN reads, then the drain, then the write.
//  - Simultaneous first requests after reset: dp granted.
//  - A cp_req drop during DRAIN returns FSM to IDLE.
//    A dp_req pending in DRAIN waits.
//  - run saturates at MAX_DP_RUN and clears on any cp grant.
//  - Reset mid-operation drops in-flight reads; dp_rvalid is 0 next cycle.
//  - Addresses pass through unchanged (no wrap logic); width is ADDR_W.
// TESTING
//  1. Reset: hold reset 2 cycles with reqs high -> all outputs 0.
//     First dp grant occurs the cycle after reset falls.
//  2. dp only, addr 0..15 back-to-back -> dp_gnt every cycle.
//     mem_read 1 cycle later; dp_rvalid at grant+3 (RD_LAT=2), data in order.
//  3. cp only, 4 writes 0x100..0x103, data 0xA0..0xA3 -> cp_gnt every cycle.
//     mem_write pulses show the matching addr/data.
//  4. dp and cp held high continuously -> 8 dp grants, then 2 DRAIN cycles.
//     Then 1 cp grant, TURN, and dp resumes. Repeats; mem_write is never
//     adjacent to mem_read.
//  5. Write followed by read: cp write 0x55 to 0x200, then dp read 0x200.
//     -> One idle mem cycle between them; dp_rdata = 0x55.
//  6. Reset asserted with 2 reads in flight -> dp_rvalid is never asserted.
//     FSM is IDLE, run=0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// sram_arbiter_if
// Groups the bus signals around sram_arbiter: the copy-engine write port, the
// display read port and the side that faces the single-port SRAM controller.
//
//   copy port    : cp_req, cp_addr, cp_wdata  -> arbiter ; cp_gnt <- arbiter
//   display port : dp_req, dp_addr            -> arbiter ; dp_gnt, dp_rvalid,
//                                                          dp_rdata <- arbiter
//   memory side  : mem_write, mem_read, mem_addr, mem_wdata <- arbiter ;
//                  mem_rdata -> arbiter
//
// Modports: slave is the arbiter itself; master is everything around it
// (both requesters plus the SRAM controller).
// -----------------------------------------------------------------------------
interface sram_arbiter_if #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
);
   logic              cp_req;
   logic [ADDR_W-1:0] cp_addr;
   logic [DATA_W-1:0] cp_wdata;
   logic              cp_gnt;
   logic              dp_req;
   logic [ADDR_W-1:0] dp_addr;
   logic              dp_gnt;
   logic              dp_rvalid;
   logic [DATA_W-1:0] dp_rdata;
   logic              mem_write;
   logic              mem_read;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cp_req, cp_addr, cp_wdata,
      output cp_gnt,
      input  dp_req, dp_addr,
      output dp_gnt, dp_rvalid, dp_rdata,
      output mem_write, mem_read, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output cp_req, cp_addr, cp_wdata,
      input  cp_gnt,
      output dp_req, dp_addr,
      input  dp_gnt, dp_rvalid, dp_rdata,
      input  mem_write, mem_read, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Shares one single-port SRAM controller between the framebuffer copy engine
// (writes only) and the VGA scanout (reads only, real-time). The display port
// normally wins; after MAX_DP_RUN consecutive display grants with a copy
// request waiting, the copy port is forced through. Before a write, all reads
// still in the memory pipeline are drained; after a write burst, one idle
// turnaround cycle is inserted before any read.
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    sram_arbiter_if.slave: cp_* copy write port, dp_* display read
//          port, mem_* registered SRAM controller commands and mem_rdata
// Grants are combinational from state, counters and requests; mem_* are
// registered and pulse for one cycle after each accepted request.
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int ADDR_W     = 20,
   parameter int DATA_W     = 8,
   parameter int RD_LAT     = 2,
   parameter int MAX_DP_RUN = 8
) (
   input  logic          clk,
   input  logic          reset,
   sram_arbiter_if.slave bus
);

   localparam int RUN_W = $clog2(MAX_DP_RUN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DP_RUN);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_TURN  = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [RUN_W-1:0]  run_r;
   logic [RUN_W-1:0]  run_nxt_s;
   logic [RD_LAT:0]   infl_r;
   logic              cp_gnt_s;
   logic              dp_gnt_s;
   logic              force_s;
   logic              infl_busy_s;
   logic              mem_write_r;
   logic              mem_read_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;

   // Next-state, run counter and grant decode
   always_comb begin
      state_nxt_s = state_r;
      run_nxt_s   = run_r;
      cp_gnt_s    = 1'b0;
      dp_gnt_s    = 1'b0;
      force_s     = bus.cp_req && (run_r == RUN_MAX);
      // Any read issued in the last RD_LAT+1 cycles may still return data.
      infl_busy_s = |infl_r;
      if (reset) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE, ST_READ: begin
               if (force_s) begin
                  state_nxt_s = ST_DRAIN;
               end else if (bus.dp_req) begin
                  dp_gnt_s    = 1'b1;
                  state_nxt_s = ST_READ;
                  // Count reads only while the copy port is kept waiting.
                  if (bus.cp_req) begin
                     if (run_r != RUN_MAX) begin
                        run_nxt_s = run_r + RUN_W'(1);
                     end else begin
                        run_nxt_s = run_r;
                     end
                  end else begin
                     run_nxt_s = '0;
                  end
               end else if (bus.cp_req && !infl_busy_s) begin
                  cp_gnt_s    = 1'b1;
                  state_nxt_s = ST_WRITE;
                  run_nxt_s   = '0;
               end else if (bus.cp_req) begin
                  state_nxt_s = ST_DRAIN;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_DRAIN: begin
               if (!bus.cp_req) begin
                  state_nxt_s = ST_IDLE;
               end else if (!infl_busy_s) begin
                  cp_gnt_s    = 1'b1;
                  state_nxt_s = ST_WRITE;
                  run_nxt_s   = '0;
               end else begin
                  state_nxt_s = ST_DRAIN;
               end
            end
            ST_WRITE: begin
               // A waiting display request ends the write burst.
               if (bus.dp_req) begin
                  state_nxt_s = ST_TURN;
               end else if (bus.cp_req) begin
                  cp_gnt_s    = 1'b1;
                  state_nxt_s = ST_WRITE;
                  run_nxt_s   = '0;
               end else begin
                  state_nxt_s = ST_TURN;
               end
            end
            ST_TURN: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, counters, read tracking and registered SRAM commands
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         run_r       <= '0;
         infl_r      <= '0;
         mem_write_r <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         run_r       <= run_nxt_s;
         // Bit 0 rises together with mem_read; bit RD_LAT marks returning data.
         infl_r      <= {infl_r[RD_LAT-1:0], dp_gnt_s};
         mem_write_r <= cp_gnt_s;
         mem_read_r  <= dp_gnt_s;
         if (cp_gnt_s) begin
            mem_addr_r  <= bus.cp_addr;
            mem_wdata_r <= bus.cp_wdata;
         end else if (dp_gnt_s) begin
            mem_addr_r  <= bus.dp_addr;
         end
      end
   end

   assign bus.cp_gnt    = cp_gnt_s;
   assign bus.dp_gnt    = dp_gnt_s;
   assign bus.dp_rvalid = infl_r[RD_LAT];
   assign bus.dp_rdata  = bus.mem_rdata;
   assign bus.mem_write = mem_write_r;
   assign bus.mem_read  = mem_read_r;
   assign bus.mem_addr  = mem_addr_r;
   assign bus.mem_wdata = mem_wdata_r;

endmodule
